// File: rtl/or_mux_rr_arbiter.sv
// Round-robin arbiter that shares one BIT-wide valid/ready channel among
// NUMBER_INPUT requesters through a one-hot select and an AND-OR data mux.
module or_mux_rr_arbiter #(
  parameter int BIT          = 29,
  parameter int NUMBER_INPUT = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUMBER_INPUT-1:0]     req,
  input  logic [NUMBER_INPUT*BIT-1:0] IN,
  input  logic                        out_ready,
  output logic [BIT-1:0]              out,
  output logic                        out_valid,
  output logic [NUMBER_INPUT-1:0]     sel,
  output logic [NUMBER_INPUT-1:0]     ack
);

  localparam int N  = NUMBER_INPUT;
  localparam int PW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, owner, ptr_eff;
  logic [N-1:0]    sel_q, sel_d, elig, win_oh;
  logic [BIT-1:0]  out_q, out_d, win_data;
  logic            vld_q, vld_d;
  logic            accept, found;

  assign accept = vld_q & out_ready;
  // rst_n is active-high; no acknowledge may escape while it is applied
  assign ack    = rst_n ? '0 : (sel_q & {N{accept}});

  always_comb begin
    owner = '0;
    for (int i = 0; i < N; i++)
      if (sel_q[i]) owner = PW'(i);
  end

  // On accept the search restarts just past the owner, with the owner masked out
  assign ptr_eff = accept ? ((owner == PW'(N-1)) ? '0 : owner + PW'(1)) : ptr_q;
  assign elig    = req & ~(accept ? sel_q : '0);

  always_comb begin
    logic [PW:0] j;
    found  = 1'b0;
    win_oh = '0;
    j      = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, ptr_eff} + (PW+1)'(i);
      if (j >= (PW+1)'(N)) j = j - (PW+1)'(N);
      if (!found && elig[j[PW-1:0]]) begin
        found              = 1'b1;
        win_oh[j[PW-1:0]]  = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++)
      win_data = win_data | (IN[i*BIT +: BIT] & {BIT{win_oh[i]}});
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = BUSY;
      BUSY:    if (accept && !found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    sel_d = sel_q;
    out_d = out_q;
    vld_d = vld_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d = win_oh;
          out_d = win_data;
          vld_d = 1'b1;
        end
      end
      BUSY: begin
        if (accept) begin
          ptr_d = ptr_eff;
          if (found) begin
            sel_d = win_oh;
            out_d = win_data;
          end else begin
            sel_d = '0;
            vld_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_or_mux_rr_arbiter.sv
// Directed bench for or_mux_rr_arbiter: a vector table plus hand-written
// sequences for rotation, stall and reset corner cases.
module tb_or_mux_rr_arbiter;

  localparam int BIT = 29;
  localparam int N   = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [N*BIT-1:0]   in_bus;
  logic               out_ready;
  logic [BIT-1:0]     out;
  logic               out_valid;
  logic [N-1:0]       sel;
  logic [N-1:0]       ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  or_mux_rr_arbiter #(.BIT(BIT), .NUMBER_INPUT(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .IN(in_bus), .out_ready(out_ready),
    .out(out), .out_valid(out_valid), .sel(sel), .ack(ack)
  );

  typedef struct packed {
    logic           rst;
    logic [N-1:0]   rq;
    logic           rdy;
    logic [7:0]     tag;
    logic [BIT-1:0] eo;
    logic           ev;
    logic [N-1:0]   es;
    logic [N-1:0]   ea;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [BIT-1:0] mk(input int i, input logic [7:0] tag);
    return (BIT'(i) << 20) | BIT'(tag);
  endfunction

  // Inputs change at the falling edge; outputs are checked 1 ns later
  task automatic drive(input logic r, input logic [N-1:0] q, input logic rd,
                       input logic [7:0] tag);
    @(negedge clk);
    rst_n     = r;
    req       = q;
    out_ready = rd;
    for (int i = 0; i < N; i++) in_bus[i*BIT +: BIT] = mk(i, tag);
    #1;
  endtask

  task automatic chk(input string nm, input logic [BIT-1:0] eo, input logic ev,
                     input logic [N-1:0] es, input logic [N-1:0] ea);
    n_cmp += 4;
    if (out !== eo) begin
      n_bad++; $display("FAIL %s out: got %h want %h", nm, out, eo);
    end
    if (out_valid !== ev) begin
      n_bad++; $display("FAIL %s out_valid: got %b want %b", nm, out_valid, ev);
    end
    if (sel !== es) begin
      n_bad++; $display("FAIL %s sel: got %h want %h", nm, sel, es);
    end
    if (ack !== ea) begin
      n_bad++; $display("FAIL %s ack: got %h want %h", nm, ack, ea);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'hFFFF, 1'b1, 8'h00, 29'h0000000, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 16'hFFFF, 1'b1, 8'h00, 29'h0000000, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b1, 16'hFFFF, 1'b1, 8'h00, 29'h0000000, 1'b0, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 8'h00, 29'h0000000, 1'b0, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b0, 16'hFFFF, 1'b1, 8'h01, 29'h0000000, 1'b0, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b0, 16'hFFFF, 1'b1, 8'h02, 29'h0000001, 1'b1, 16'h0001, 16'h0001};
    tbl[6]  = '{1'b0, 16'hFFFF, 1'b1, 8'h03, 29'h0100002, 1'b1, 16'h0002, 16'h0002};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 8'h04, 29'h0200003, 1'b1, 16'h0004, 16'h0000};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 8'h05, 29'h0200003, 1'b1, 16'h0004, 16'h0004};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 8'h05, 29'h0200003, 1'b0, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 16'h0021, 1'b1, 8'h06, 29'h0200003, 1'b0, 16'h0000, 16'h0000};
    tbl[11] = '{1'b0, 16'h0021, 1'b1, 8'h07, 29'h0500006, 1'b1, 16'h0020, 16'h0020};
    tbl[12] = '{1'b0, 16'h0021, 1'b1, 8'h08, 29'h0000007, 1'b1, 16'h0001, 16'h0001};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 8'h09, 29'h0500008, 1'b1, 16'h0020, 16'h0020};
    tbl[14] = '{1'b0, 16'h0010, 1'b0, 8'h0A, 29'h0500008, 1'b0, 16'h0000, 16'h0000};
    tbl[15] = '{1'b1, 16'h0010, 1'b1, 8'h0B, 29'h040000A, 1'b1, 16'h0010, 16'h0000};
    tbl[16] = '{1'b0, 16'h0090, 1'b0, 8'h0C, 29'h0000000, 1'b0, 16'h0000, 16'h0000};
    tbl[17] = '{1'b0, 16'h0000, 1'b1, 8'h0D, 29'h040000C, 1'b1, 16'h0010, 16'h0010};
    tbl[18] = '{1'b0, 16'h0000, 1'b1, 8'h0E, 29'h040000C, 1'b0, 16'h0000, 16'h0000};

    rst_n = 1'b1; req = '0; out_ready = 1'b0; in_bus = '0;
    drive(1'b1, 16'hFFFF, 1'b1, 8'h00);

    for (int k = 0; k < 19; k++) begin
      drive(tbl[k].rst, tbl[k].rq, tbl[k].rdy, tbl[k].tag);
      chk($sformatf("tbl%0d", k), tbl[k].eo, tbl[k].ev, tbl[k].es, tbl[k].ea);
    end

    // single transfer of a specific slice, owner drops req in its ack cycle
    drive(1'b1, 16'h0000, 1'b1, 8'h00);
    drive(1'b0, 16'h0008, 1'b1, 8'h00);
    in_bus[3*BIT +: BIT] = 29'h1ABCDEF;
    chk("single_req", 29'h0000000, 1'b0, 16'h0000, 16'h0000);
    drive(1'b0, 16'h0000, 1'b1, 8'h00);
    chk("single_grant", 29'h1ABCDEF, 1'b1, 16'h0008, 16'h0008);
    drive(1'b0, 16'h0000, 1'b1, 8'h00);
    chk("single_idle", 29'h1ABCDEF, 1'b0, 16'h0000, 16'h0000);

    // full rotation with every requester active, including 15 -> 0 wrap
    drive(1'b1, 16'h0000, 1'b1, 8'h00);
    drive(1'b0, 16'hFFFF, 1'b1, 8'h00);
    chk("rot_start", 29'h0000000, 1'b0, 16'h0000, 16'h0000);
    for (int k = 0; k < 17; k++) begin
      logic [N-1:0] oh;
      oh = 16'h0001 << (k % 16);
      drive(1'b0, 16'hFFFF, 1'b1, 8'(k + 1));
      chk($sformatf("rot%0d", k), mk(k % 16, 8'(k)), 1'b1, oh, oh);
    end

    // stall: owner 2 held while req and data churn
    drive(1'b1, 16'h0000, 1'b0, 8'h00);
    drive(1'b0, 16'h0004, 1'b0, 8'h11);
    chk("stall_req", 29'h0000000, 1'b0, 16'h0000, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] rq;
      rq = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
      drive(1'b0, rq, 1'b0, 8'(8'h20 + k));
      chk($sformatf("stall%0d", k), mk(2, 8'h11), 1'b1, 16'h0004, 16'h0000);
    end
    drive(1'b0, 16'h0000, 1'b1, 8'h30);
    chk("stall_ack", mk(2, 8'h11), 1'b1, 16'h0004, 16'h0004);
    drive(1'b0, 16'h0000, 1'b1, 8'h31);
    chk("stall_idle", mk(2, 8'h11), 1'b0, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
